proc_ctrl_fsm: RTL

Multicycle control sequencer for the 64-entry x 32-bit processor core.
- Fetches each instruction from instruction memory with a req/ack handshake and owns the 6-bit PC.
- Decodes the instruction word into register addresses, funct and sign-extended immediate.
- Steps the datapath through DECODE/EXEC/MEM/WB and drives register-file and data-memory enables.
- Sits between the instruction memory, the register array/ALU and the data memory.

---
 rtl/proc_ctrl_fsm.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl_fsm
//  Description : Multicycle control sequencer for the 64 x 32-bit core.
//                Fetches over a req/ack handshake, owns the 6-bit PC,
//                decodes the instruction and steps the datapath through
//                DECODE / EXEC / MEM / WB.
//                Optional macro PROC_CTRL_TIMEOUT_EN bounds every
//                handshake wait to TIMEOUT_CYCLES and flags err.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_ctrl_fsm #(
    parameter logic [5:0] START_PC       = 6'd0,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clkreset,
    input  logic        start,
    output logic        imem_req,
    output logic [5:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        alu_zero,
    input  logic        dmem_ack,
    output logic [5:0]  pc,
    output logic [31:0] instr_q,
    output logic [5:0]  rs_addr,
    output logic [5:0]  rt_addr,
    output logic [5:0]  rd_addr,
    output logic [3:0]  funct,
    output logic [31:0] imm_ext,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic        rf_wsel_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] F_LOAD  = 4'h8;
    localparam logic [3:0] F_STORE = 4'h9;
    localparam logic [3:0] F_BEQZ  = 4'hA;
    localparam logic [3:0] F_HALT  = 4'hF;

    logic [2:0]  state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [31:0] instr_d;
    logic        w_is_load, w_is_store;
    logic        w_timeout;   // current wait has used up its budget
    logic        w_waiting;   // handshake outstanding with no ack this cycle

    assign w_is_load  = (funct == F_LOAD);
    assign w_is_store = (funct == F_STORE);
    assign w_waiting  = ((state_q == S_FETCH) && !imem_ack) ||
                        ((state_q == S_MEM)   && !dmem_ack);

    // Field decode straight from the latched word; stable from DECODE onward
    always_comb begin
        rs_addr = instr_q[6:1];
        rd_addr = instr_q[12:7];
        funct   = instr_q[16:13];
        if (instr_q[0]) begin
            rt_addr = 6'd0;
            imm_ext = {{17{instr_q[31]}}, instr_q[31:17]};
        end else begin
            rt_addr = instr_q[22:17];
            imm_ext = {{23{instr_q[31]}}, instr_q[31:23]};
        end
    end

    // Next-state, PC and instruction-latch logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = START_PC;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (funct == F_HALT) begin
                    state_d = S_HALT;
                end else if (funct == F_BEQZ) begin
                    // Branch offset only needs the low PC-width bits; wraps mod 64
                    pc_d    = alu_zero ? (pc_q + 6'd1 + imm_ext[5:0]) : (pc_q + 6'd1);
                    state_d = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (w_is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else if (w_timeout) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                pc_d    = pc_q + 6'd1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Core state registers
    always_ff @(posedge clk or negedge clkreset) begin
        if (!clkreset) begin
            state_q <= S_IDLE;
            pc_q    <= 6'd0;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef PROC_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             w_start_ok;

    assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign w_timeout  = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait counter restarts on every state change and advances while stalled
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (w_waiting) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Sticky timeout flag, cleared by an accepted start
    always_comb begin
        err_d = err_q;
        if (w_start_ok) begin
            err_d = 1'b0;
        end else if (w_timeout && w_waiting) begin
            err_d = 1'b1;
        end
    end

    // Timeout registers
    always_ff @(posedge clk or negedge clkreset) begin
        if (!clkreset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (^TIMEOUT_CYCLES) ^ w_waiting;
    assign w_timeout    = 1'b0;
    assign err          = 1'b0;
`endif

    assign state       = state_q;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == S_FETCH);
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = (state_q == S_MEM) && w_is_store;
    assign rf_we       = (state_q == S_WB) && (rd_addr != 6'd0);
    assign rf_wsel_mem = (state_q == S_WB) && w_is_load;
    assign alu_src_imm = instr_q[0] || w_is_load || w_is_store;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);

endmodule
`default_nettype wire
